// File: rtl/y86_isa_pkg.sv
// Y86-64 ISA constants shared by the instruction encoder and its byte packer.
package y86_isa_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  typedef logic [9:0][7:0] instr_bytes_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_ERR
  } enc_state_t;

  // Encoded length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      IHALT, INOP, IRET:             instr_len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  instr_len = 4'd2;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     instr_len = 4'd10;
      IJXX, ICALL:                   instr_len = 4'd9;
      default:                       instr_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_pack.sv
// Combinational packer: lays out one Y86-64 instruction as up to 10 bytes.
module y86_instr_pack
  import y86_isa_pkg::*;
(
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [3:0]   ra,
  input  logic [3:0]   rb,
  input  logic [63:0]  valc,
  output instr_bytes_t bytes,
  output logic [3:0]   len,
  output logic         valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    bytes    = '0;
    bytes[0] = {icode, ifun};
    case (icode)
      IRRMOVQ, IOPQ:    bytes[1] = {ra, rb};
      IPUSHQ, IPOPQ:    bytes[1] = {ra, RNONE};
      IIRMOVQ: begin
        bytes[1]   = {RNONE, rb};
        bytes[9:2] = valc;
      end
      IRMMOVQ, IMRMOVQ: begin
        bytes[1]   = {ra, rb};
        bytes[9:2] = valc;
      end
      IJXX, ICALL:      bytes[8:1] = valc;
      default:          ;
    endcase
  end

  assign len   = instr_len(icode);
  assign valid = (len != 4'd0);

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder / instruction-memory loader, one byte per cycle.
// Optional running XOR checksum output enc_csum when Y86_ENC_CHECKSUM_EN is defined.
module y86_instr_encoder
  import y86_isa_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int PTR_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_addr,
  input  logic [PTR_W-1:0] start_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [3:0]       in_rA,
  input  logic [3:0]       in_rB,
  input  logic [63:0]      in_valC,
  output logic             mem_we,
  output logic [PTR_W-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [15:0]      instr_count,
  output logic [1:0]       enc_stat,
  output logic             busy
`ifdef Y86_ENC_CHECKSUM_EN
  ,
  output logic [7:0]       enc_csum
`endif
);

  localparam logic [PTR_W:0] MEM_LIMIT = (PTR_W+1)'(MEM_DEPTH);

  enc_state_t       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]      instr_count_q, instr_count_d;
  logic [1:0]       enc_stat_q, enc_stat_d;
  logic             mem_we_q, mem_we_d;
  logic [PTR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  instr_bytes_t     bytes_q, bytes_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic             halt_q, halt_d;
`ifdef Y86_ENC_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  instr_bytes_t     pk_bytes;
  logic [3:0]       pk_len;
  logic             pk_valid;
  logic [PTR_W-1:0] accept_ptr;
  logic [PTR_W:0]   end_addr;

  y86_instr_pack u_pack (
    .icode (in_icode),
    .ifun  (in_ifun),
    .ra    (in_rA),
    .rb    (in_rB),
    .valc  (in_valC),
    .bytes (pk_bytes),
    .len   (pk_len),
    .valid (pk_valid)
  );

  // A same-cycle load_addr relocates the instruction being accepted.
  assign accept_ptr = load_addr ? start_addr : wr_ptr_q;
  assign end_addr   = {1'b0, accept_ptr} + (PTR_W+1)'(pk_len);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    instr_count_d = instr_count_q;
    enc_stat_d    = enc_stat_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bytes_d       = bytes_q;
    len_d         = len_q;
    idx_d         = idx_q;
    halt_d        = halt_q;
`ifdef Y86_ENC_CHECKSUM_EN
    csum_d        = mem_we_q ? (csum_q ^ mem_wdata_q) : csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_addr) begin
          wr_ptr_d = start_addr;
`ifdef Y86_ENC_CHECKSUM_EN
          csum_d   = 8'h00;
`endif
        end
        if (in_valid) begin
          if (!pk_valid) begin
            state_d    = S_ERR;
            enc_stat_d = STAT_INS;
          end else if (end_addr > MEM_LIMIT) begin
            state_d    = S_ERR;
            enc_stat_d = STAT_ADR;
          end else begin
            state_d     = S_EMIT;
            bytes_d     = pk_bytes;
            len_d       = pk_len;
            halt_d      = (in_icode == IHALT);
            idx_d       = 4'd1;
            mem_we_d    = 1'b1;
            mem_addr_d  = accept_ptr;
            mem_wdata_d = pk_bytes[0];
          end
        end
      end
      S_EMIT: begin
        if (idx_q == len_q) begin
          state_d       = S_IDLE;
          wr_ptr_d      = wr_ptr_q + PTR_W'(len_q);
          instr_count_d = instr_count_q + 16'd1;
          if (halt_q) enc_stat_d = STAT_HLT;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q + PTR_W'(idx_q);
          mem_wdata_d = bytes_q[idx_q];
          idx_d       = idx_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      instr_count_q <= '0;
      enc_stat_q    <= STAT_AOK;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
`ifdef Y86_ENC_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_count_q <= instr_count_d;
      enc_stat_q    <= enc_stat_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
`ifdef Y86_ENC_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // NOTE: the byte buffer and its index are not reset; they are only read in EMIT, which is reached via an accept that loads them.
  always_ff @(posedge clk) begin
    bytes_q <= bytes_d;
    len_q   <= len_d;
    idx_q   <= idx_d;
    halt_q  <= halt_d;
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_EMIT);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr      = wr_ptr_q;
  assign instr_count = instr_count_q;
  assign enc_stat    = enc_stat_q;
`ifdef Y86_ENC_CHECKSUM_EN
  assign enc_csum    = csum_q;
`endif

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: expected memory writes are queued, a monitor checks them.
module tb_y86_instr_encoder;

  logic        clk;
  logic        rst;
  logic        load_addr;
  logic [63:0] start_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] wr_ptr;
  logic [15:0] instr_count;
  logic [1:0]  enc_stat;
  logic        busy;
`ifdef Y86_ENC_CHECKSUM_EN
  logic [7:0]  enc_csum;
`endif

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  y86_instr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .load_addr   (load_addr),
    .start_addr  (start_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_icode    (in_icode),
    .in_ifun     (in_ifun),
    .in_rA       (in_rA),
    .in_rB       (in_rB),
    .in_valC     (in_valC),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wr_ptr      (wr_ptr),
    .instr_count (instr_count),
    .enc_stat    (enc_stat),
    .busy        (busy)
`ifdef Y86_ENC_CHECKSUM_EN
    ,
    .enc_csum    (enc_csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every committed byte must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%02h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", {56'h0, mem_wdata}, {56'h0, e.data});
      end
    end
  end

  // bytes holds byte0 in its most significant used position (n bytes right-aligned).
  task automatic expect_seq(input logic [63:0] base, input int n, input logic [79:0] bytes);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = base + 64'(k);
      e.data = bytes[(n-1-k)*8 +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc,
                       input logic ld, input logic [63:0] sa);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=%b, required 1", in_ready);
    end else begin
      in_icode   = ic;
      in_ifun    = ifn;
      in_rA      = ra;
      in_rB      = rb;
      in_valC    = vc;
      load_addr  = ld;
      start_addr = sa;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      load_addr = 1'b0;
    end
  endtask

  task automatic wait_idle(output int cyc);
    bit ok = 0;
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      cyc++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got in_ready=%b after %0d cycles, required 1", in_ready, cyc);
    end
  endtask

  task automatic run(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] base,
                     input int n, input logic [79:0] bytes, output int cyc);
    expect_seq(base, n, bytes);
    issue(ic, ifn, ra, rb, vc, 1'b0, 64'h0);
    wait_idle(cyc);
  endtask

  task automatic pulse_load(input logic [63:0] sa);
    @(negedge clk);
    load_addr  = 1'b1;
    start_addr = sa;
    @(posedge clk);
    #1;
    load_addr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  int cyc;

  initial begin
    rst = 1'b1; load_addr = 1'b0; start_addr = '0; in_valid = 1'b0;
    in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_wr_ptr", wr_ptr, 64'h0);
    check("rst_instr_count", {48'h0, instr_count}, 64'h0);
    check("rst_enc_stat", {62'h0, enc_stat}, 64'h0);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", {56'h0, mem_wdata}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);

    // irmovq: rA forced to F, valC little-endian
    run(4'h3, 4'h0, 4'h2, 4'h3, 64'h0123456789ABCDEF, 64'd0, 10,
        80'h30_F3_EF_CD_AB_89_67_45_23_01, cyc);
    check("irmovq_busy_cycles", 64'(cyc), 64'd10);
    check("irmovq_wr_ptr", wr_ptr, 64'd10);
    check("irmovq_count", {48'h0, instr_count}, 64'd1);
`ifdef Y86_ENC_CHECKSUM_EN
    check("irmovq_csum", {56'h0, enc_csum}, 64'hC3);
`endif

    run(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd10, 9, 80'h70_40_00_00_00_00_00_00_00, cyc);
    check("jxx_ready_low_cycles", 64'(cyc), 64'd9);
    check("jxx_wr_ptr", wr_ptr, 64'd19);

    run(4'hA, 4'h0, 4'h0, 4'h5, 64'h0, 64'd19, 2, 80'hA0_0F, cyc);
    check("pushq_wr_ptr", wr_ptr, 64'd21);
    check("pushq_stat", {62'h0, enc_stat}, 64'h0);
    run(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'd21, 1, 80'h00, cyc);
    check("halt_stat", {62'h0, enc_stat}, 64'h1);
    check("halt_in_ready", {63'h0, in_ready}, 64'h1);
    check("halt_wr_ptr", wr_ptr, 64'd22);

    run(4'h2, 4'h0, 4'h1, 4'h4, 64'h0, 64'd22, 2, 80'h20_14, cyc);
    run(4'h6, 4'h1, 4'h3, 4'h7, 64'h0, 64'd24, 2, 80'h61_37, cyc);
    run(4'hB, 4'h0, 4'h6, 4'h0, 64'h0, 64'd26, 2, 80'hB0_6F, cyc);
    run(4'h8, 4'h0, 4'h0, 4'h0, 64'h123, 64'd28, 9, 80'h80_23_01_00_00_00_00_00_00, cyc);
    run(4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 64'd37, 1, 80'h90, cyc);
    run(4'h5, 4'h0, 4'h2, 4'h4, 64'h10, 64'd38, 10, 80'h50_24_10_00_00_00_00_00_00_00, cyc);
    run(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 64'd48, 1, 80'h10, cyc);
    check("mix_wr_ptr", wr_ptr, 64'd49);
    check("mix_count", {48'h0, instr_count}, 64'd11);
    check("mix_stat_sticky_hlt", {62'h0, enc_stat}, 64'h1);

    // load_addr with the instruction in the same cycle: rmmovq fills 1014..1023 exactly
    expect_seq(64'd1014, 10, 80'h40_12_EF_BE_AD_DE_00_00_00_00);
    issue(4'h4, 4'h0, 4'h1, 4'h2, 64'hDEADBEEF, 1'b1, 64'd1014);
    wait_idle(cyc);
    check("edge_wr_ptr", wr_ptr, 64'd1024);
    check("edge_count", {48'h0, instr_count}, 64'd12);
`ifdef Y86_ENC_CHECKSUM_EN
    check("edge_csum", {56'h0, enc_csum}, 64'h70);
`endif

    pulse_load(64'd1020);
    @(negedge clk);
    check("load_wr_ptr", wr_ptr, 64'd1020);
    issue(4'h3, 4'h0, 4'h0, 4'h1, 64'h55, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    check("adr_stat", {62'h0, enc_stat}, 64'h2);
    check("adr_in_ready", {63'h0, in_ready}, 64'h0);
    check("adr_busy", {63'h0, busy}, 64'h0);
    pulse_load(64'd5);
    repeat (2) @(negedge clk);
    check("err_load_ignored", wr_ptr, 64'd1020);
    check("err_in_ready", {63'h0, in_ready}, 64'h0);

    do_reset();
    check("rst2_wr_ptr", wr_ptr, 64'h0);
    check("rst2_stat", {62'h0, enc_stat}, 64'h0);
    check("rst2_in_ready", {63'h0, in_ready}, 64'h1);
    issue(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    check("ins_stat", {62'h0, enc_stat}, 64'h3);
    check("ins_in_ready", {63'h0, in_ready}, 64'h0);
    pulse_load(64'd100);
    @(negedge clk);
    check("ins_load_ignored", wr_ptr, 64'h0);

    // reset during the 4th byte of mrmovq: only bytes 0..3 reach memory
    do_reset();
    expect_seq(64'd0, 4, 80'h50_24_10_00);
    issue(4'h5, 4'h0, 4'h2, 4'h4, 64'h10, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_we", {63'h0, mem_we}, 64'h0);
    check("midrst_wr_ptr", wr_ptr, 64'h0);
    check("midrst_count", {48'h0, instr_count}, 64'h0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
`ifdef Y86_ENC_CHECKSUM_EN
    check("midrst_csum", {56'h0, enc_csum}, 64'h0);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
Y86-64 instruction encoder and instruction-memory loader. It accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake. It serializes each instruction into the exact byte layout the fetch stage decodes, and writes one byte per cycle into the 1024-byte instruction memory at an auto-advancing write pointer. Typical uses are bench program loading and self-test.

Parameters:
MEM_DEPTH, 1024, instruction memory size in bytes; an instruction whose bytes would reach address MEM_DEPTH or beyond is rejected.
PTR_W, 64, width of the address and write pointer, matching the pipeline PC width.

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-high reset
load_addr  in  1  pulse: wr_ptr <= start_addr; honoured only in IDLE
start_addr  in  64  new write pointer value
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept; high only in IDLE
in_icode  in  4  instruction code
in_ifun  in  4  function code
in_rA  in  4  register A
in_rB  in  4  register B
in_valC  in  64  constant word
mem_we  out  1  byte write strobe
mem_addr  out  64  byte address
mem_wdata  out  8  byte data
wr_ptr  out  64  next free byte address
instr_count  out  16  instructions fully written; wraps modulo 2^16
enc_stat  out  2  status: 00 AOK, 01 HLT, 10 ADR, 11 INS
busy  out  1  high in EMIT

Behaviour:
- Reset (synchronous, active-high): state IDLE, wr_ptr=0, instr_count=0, enc_stat=00, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=1 on the cycle after the reset edge.
- States:
  - IDLE: in_ready=1.
  - EMIT: mem_we=1, one byte per cycle.
  - ERR: in_ready=0, mem_we=0; sticky until rst.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovq, 6 OPq, A pushq, B popq: 2 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - icode > 0xB is invalid.
- Byte layout:
  - byte0 = {icode, ifun}.
  - Register forms: byte1 = {rA, rB}; irmovq forces rA=F; pushq/popq force rB=F.
  - 10-byte forms: bytes 2..9 = valC little-endian (byte2 = valC[7:0]).
  - jXX/call: bytes 1..8 = valC little-endian.
  - ifun is written as given, without validation.
- Accept edge is the edge where in_valid & in_ready:
  - Invalid icode: go to ERR, enc_stat=11, no writes.
  - wr_ptr + len > MEM_DEPTH: go to ERR, enc_stat=10, no writes.
  - Otherwise: latch the fields, byte index=0, go to EMIT.
- EMIT timing:
  - For accept edge T, byte k is driven in the cycle after edge T+k, with mem_addr = wr_ptr + k. All outputs are registered.
  - On the edge that ends the last byte: wr_ptr += len, instr_count += 1, return to IDLE.
  - in_ready rises the cycle after the last byte, so throughput is one instruction per len+1 cycles.
- Halt: after a halt completes, enc_stat=01. Accepting continues. A later error overrides it with 10 or 11.
- load_addr:
  - In EMIT or ERR it is ignored.
  - If load_addr and an accepted in_valid occur in the same IDLE cycle, load_addr takes precedence and the instruction is encoded at start_addr.
- wr_ptr never wraps: the ADR check fires first.
- rst mid-EMIT: the remaining bytes are dropped, mem_we=0 from the next cycle, and all reset values apply.

Optional Feature:
Macro Y86_ENC_CHECKSUM_EN.
- Defined: extra output port enc_csum [7:0], the running XOR of every byte written with mem_we=1. It is cleared by rst and by an honoured load_addr, and updated on the same edge the byte is committed.
- Undefined: the port is absent and there is no checksum logic. All other behaviour is identical.

Decomposition:
- Package y86_isa_pkg:
  - icode constants (IHALT..IPOPQ).
  - RNONE=4'hF.
  - Status constants STAT_AOK/HLT/ADR/INS.
  - Function instr_len(icode) returning 0 for invalid codes.
- Sub-module y86_instr_pack (combinational): takes the fields and produces a 10-byte array plus length and valid. The top holds the FSM, wr_ptr, counters and the byte mux.

Test Plan:
- rst; irmovq icode=3, rA=2, rB=3, valC=0x0123456789ABCDEF at wr_ptr=0 -> addr 0..9 = 30 F3 EF CD AB 89 67 45 23 01 over 10 consecutive cycles; wr_ptr=10; instr_count=1.
- Then jXX icode=7, ifun=0, valC=0x40 -> addr 10..18 = 70 40 00 00 00 00 00 00 00; wr_ptr=19; in_ready low for 9 cycles.
- pushq rA=0, rB=5, then halt -> bytes A0 0F, then 00; enc_stat=01; in_ready stays high.
- load_addr with start_addr=1020, then irmovq -> no mem_we, enc_stat=10, in_ready=0 until rst; a rmmovq with start_addr=1014 writes exactly addr 1014..1023.
- icode=0xC -> no writes, enc_stat=11; a load_addr pulse in ERR leaves wr_ptr unchanged.
- rst asserted on the 4th byte of mrmovq -> mem_we=0 the next cycle, wr_ptr=0, instr_count=0; with Y86_ENC_CHECKSUM_EN, enc_csum=00.
